instr_fetch_stage: RTL and testbench

- Sequential fetch stage directly upstream of Sign_Extend in the RISC-V core.
- Holds the PC and fetches 32-bit instructions from an instruction memory over a req/ack handshake with variable latency.
- Latches each fetched word in an instruction register and presents Instr[31:7] to Sign_Extend (its 25-bit In) with a valid/ready handshake to decode.
- Accepts branch/jump redirects, including redirects that arrive while a fetch is still outstanding.

---
 rtl/core_pkg.sv | 15 +
 rtl/pc_reg.sv | 34 +++
 rtl/instr_fetch_stage.sv | 118 +++++++++++
 tb/tb_instr_fetch_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared front-end types and constants for the RISC-V core.
// Pure declarations: no latency, no backpressure.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter with load enable and a PC+4 / redirect-target next-PC mux.
// Updates one cycle after load_en; no backpressure of its own.
module pc_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic            sel_target,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_next;

  // Target low bits are dropped so the fetch address is always word aligned.
  always_comb begin
    pc_next = pc + PC_STEP;
    if (sel_target) begin
      pc_next = pc_target & ~32'h3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, req/ack instruction-memory fetch, instruction register to decode.
// Best case one instruction per 3 cycles; holds Instr stable while Instr_Ready is low.
module instr_fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_RD,
  input  logic        PCSrc,
  input  logic [31:0] PC_Target,
  input  logic        Instr_Ready,
  output logic        Instr_Valid,
  output logic [31:0] Instr,
  output logic [24:0] Imm_In,
  output logic [31:0] PC_Out,
  output logic [31:0] PCPlus4,
  output logic        Fetch_Err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  fetch_state_t     state;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  addr_q;
  logic             flush;
  logic [CNT_W-1:0] wait_cnt;
  logic             pc_load;

  // Redirects always win; otherwise the PC only advances when decode takes the instruction.
  assign pc_load = PCSrc || ((state == VALID) && Instr_Ready);

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .load_en    (pc_load),
    .sel_target (PCSrc),
    .pc_target  (PC_Target),
    .pc         (pc)
  );

  // In WAIT the address is frozen even if a redirect has already moved the PC.
  assign IMem_Addr = (state == WAIT) ? addr_q : pc;
  assign Imm_In    = Instr[31:7];
  assign PCPlus4   = PC_Out + PC_STEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      IMem_Req    <= 1'b0;
      Instr_Valid <= 1'b0;
      Instr       <= NOP_INSTR;
      PC_Out      <= RESET_PC;
      addr_q      <= RESET_PC;
      flush       <= 1'b0;
      wait_cnt    <= '0;
      Fetch_Err   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          // The first cycle out of reset only raises the request.
          IMem_Req <= 1'b1;
          if (IMem_Req && !PCSrc) begin
            state  <= WAIT;
            addr_q <= pc;
          end
        end

        WAIT: begin
          if (IMem_Ack) begin
            wait_cnt <= '0;
            flush    <= 1'b0;
            if (flush || PCSrc) begin
              state <= FETCH;
            end else begin
              Instr       <= IMem_RD;
              PC_Out      <= pc;
              state       <= VALID;
              IMem_Req    <= 1'b0;
              Instr_Valid <= 1'b1;
            end
          end else begin
            if (PCSrc) begin
              flush <= 1'b1;
            end
            if (wait_cnt != WAIT_LIMIT) begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (wait_cnt == WAIT_LIMIT - CNT_W'(1)) begin
              Fetch_Err <= 1'b1;
            end
          end
        end

        VALID: begin
          if (PCSrc || Instr_Ready) begin
            state       <= FETCH;
            Instr_Valid <= 1'b0;
            IMem_Req    <= 1'b1;
          end
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed vector table, corner sequences, random run vs PC model.
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          MAX_WAIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ack, pcsrc, rdy;
  logic [31:0] rd, tgt;
  logic        req, vld, err;
  logic [31:0] addr, instr, pc_out, pc4;
  logic [24:0] imm;

  logic        ack2, pcsrc2, rdy2;
  logic [31:0] rd2, tgt2;
  logic        req2, vld2, err2;
  logic [31:0] addr2, instr2, pc_out2, pc4_2;
  logic [24:0] imm2;

  instr_fetch_stage #(.RESET_PC(32'h0000_0000), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .IMem_Req(req), .IMem_Addr(addr), .IMem_Ack(ack), .IMem_RD(rd),
    .PCSrc(pcsrc), .PC_Target(tgt), .Instr_Ready(rdy),
    .Instr_Valid(vld), .Instr(instr), .Imm_In(imm), .PC_Out(pc_out),
    .PCPlus4(pc4), .Fetch_Err(err)
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(MAX_WAIT)) dut_wrap (
    .clk(clk), .rst(rst),
    .IMem_Req(req2), .IMem_Addr(addr2), .IMem_Ack(ack2), .IMem_RD(rd2),
    .PCSrc(pcsrc2), .PC_Target(tgt2), .Instr_Ready(rdy2),
    .Instr_Valid(vld2), .Instr(instr2), .Imm_In(imm2), .PC_Out(pc_out2),
    .PCPlus4(pc4_2), .Fetch_Err(err2)
  );

  typedef struct {
    logic        ack;
    logic [31:0] rd;
    logic        pcsrc;
    logic [31:0] tgt;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic a, input logic [31:0] r, input logic p,
                              input logic [31:0] t, input logic y, input logic er,
                              input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.ack = a;  v.rd = r;  v.pcsrc = p;  v.tgt = t;  v.rdy = y;
    v.e_req = er;  v.e_addr = ea;  v.e_vld = ev;  v.e_instr = ei;  v.e_pc = ep;
    return v;
  endfunction

  // Memory contents as a function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ NOP;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[20];
    vec_t        v;
    logic [31:0] nop_v, exp_i, r4;
    logic [31:0] pc_exp, last_addr;
    int          held, lat, accepted;

    tbl[0]  = mk(1'b0, 32'h0,          1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, NOP,           32'h0);
    tbl[1]  = mk(1'b0, 32'h0,          1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   1'b0, NOP,           32'h0);
    tbl[2]  = mk(1'b1, 32'h00A0_0093,  1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, NOP,           32'h0);
    tbl[3]  = mk(1'b0, 32'h0,          1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h00A0_0093, 32'h0);
    tbl[4]  = mk(1'b0, 32'h0,          1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   1'b0, 32'h00A0_0093, 32'h0);
    tbl[5]  = mk(1'b1, 32'h0020_0113,  1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   1'b0, 32'h00A0_0093, 32'h0);
    for (int i = 6; i <= 10; i++)
      tbl[i] = mk(1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h0020_0113, 32'h4);
    tbl[11] = mk(1'b0, 32'h0,          1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h0020_0113, 32'h4);
    tbl[12] = mk(1'b0, 32'h0,          1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   1'b0, 32'h0020_0113, 32'h4);
    tbl[13] = mk(1'b0, 32'h0,          1'b1, 32'h103, 1'b0, 1'b1, 32'h8,   1'b0, 32'h0020_0113, 32'h4);
    tbl[14] = mk(1'b0, 32'h0,          1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   1'b0, 32'h0020_0113, 32'h4);
    tbl[15] = mk(1'b1, 32'hDEAD_BEEF,  1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   1'b0, 32'h0020_0113, 32'h4);
    tbl[16] = mk(1'b0, 32'h0,          1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b0, 32'h0020_0113, 32'h4);
    tbl[17] = mk(1'b1, 32'h0050_0293,  1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b0, 32'h0020_0113, 32'h4);
    tbl[18] = mk(1'b0, 32'h0,          1'b1, 32'h40,  1'b1, 1'b0, 32'h0,   1'b1, 32'h0050_0293, 32'h100);
    tbl[19] = mk(1'b0, 32'h0,          1'b0, 32'h0,   1'b0, 1'b1, 32'h40,  1'b0, 32'h0050_0293, 32'h100);

    ack = 1'b0; rd = '0; pcsrc = 1'b0; tgt = '0; rdy = 1'b0;
    ack2 = 1'b0; rd2 = '0; pcsrc2 = 1'b0; tgt2 = '0; rdy2 = 1'b0;
    nop_v = NOP;

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b0;
    #2;
    chkb("rst_req", req, 1'b0);
    chkb("rst_vld", vld, 1'b0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_pcplus4", pc4, 32'h4);
    chk("rst_imm", 32'(imm), 32'(nop_v[31:7]));
    chkb("rst_err", err, 1'b0);
    chk("rst_wrap_pc_out", pc_out2, 32'hFFFF_FFFC);
    chk("rst_wrap_pcplus4", pc4_2, 32'h0);

    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      v = tbl[i];
      chkb($sformatf("vec%0d_req", i), req, v.e_req);
      chkb($sformatf("vec%0d_vld", i), vld, v.e_vld);
      chk($sformatf("vec%0d_instr", i), instr, v.e_instr);
      chk($sformatf("vec%0d_pc_out", i), pc_out, v.e_pc);
      chkb($sformatf("vec%0d_err", i), err, 1'b0);
      if (v.e_req) chk($sformatf("vec%0d_addr", i), addr, v.e_addr);
      if (v.e_vld) begin
        chk($sformatf("vec%0d_imm", i), 32'(imm), 32'(v.e_instr[31:7]));
        chk($sformatf("vec%0d_pcplus4", i), pc4, v.e_pc + 32'd4);
      end
      ack = v.ack; rd = v.rd; pcsrc = v.pcsrc; tgt = v.tgt; rdy = v.rdy;
      step();
    end
    ack = 1'b0; pcsrc = 1'b0; rdy = 1'b0;

    // Ack withheld: the flag appears once MAX_WAIT whole WAIT cycles have elapsed.
    for (int done = 0; done < 20; done++) begin
      chkb($sformatf("wait%0d_err", done), err, done >= MAX_WAIT);
      chk($sformatf("wait%0d_addr", done), addr, 32'h40);
      step();
    end
    ack = 1'b1; rd = 32'h0030_0193;
    step();
    ack = 1'b0;
    chkb("err_sticky_after_ack", err, 1'b1);
    chkb("late_fetch_vld", vld, 1'b1);
    chk("late_fetch_instr", instr, 32'h0030_0193);
    chk("late_fetch_pc_out", pc_out, 32'h40);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    chk("after_late_addr", addr, 32'h44);
    step();
    step();

    // Reset mid-WAIT, between clock edges.
    #2 rst = 1'b0;
    #1;
    chkb("midrst_req", req, 1'b0);
    chkb("midrst_vld", vld, 1'b0);
    chk("midrst_instr", instr, NOP);
    chk("midrst_pc_out", pc_out, 32'h0);
    chkb("midrst_err", err, 1'b0);
    chk("midrst_addr", addr, 32'h0);

    @(posedge clk);
    #1 rst = 1'b1;
    ack = 1'b1;
    step();
    chkb("postrst_req", req, 1'b1);
    chk("postrst_addr", addr, 32'h0);
    step();
    ack = 1'b0;
    chkb("stale_ack_ignored_vld", vld, 1'b0);
    chkb("stale_ack_ignored_req", req, 1'b1);

    // Wrap-around instance: last word of the address space, then address 0.
    chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    r4 = 32'h0070_0393;
    ack2 = 1'b1; rd2 = r4;
    step();
    ack2 = 1'b0;
    chkb("wrap_vld", vld2, 1'b1);
    chk("wrap_instr", instr2, r4);
    chk("wrap_imm", 32'(imm2), 32'(r4[31:7]));
    chk("wrap_pc_out", pc_out2, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", pc4_2, 32'h0);
    chkb("wrap_err", err2, 1'b0);
    rdy2 = 1'b1;
    step();
    rdy2 = 1'b0;
    chkb("wrap_next_req", req2, 1'b1);
    chk("wrap_next_addr", addr2, 32'h0);

    // Random run: the delivered instruction must always come from the architectural PC,
    // which moves only on redirects (to the aligned target) or on acceptance (+4).
    pc_exp = 32'h0; last_addr = 32'h0; held = -1; lat = 1; accepted = 0;
    for (int c = 0; c < 3000; c++) begin
      if (req) chk("rand_align", addr & 32'h3, 32'h0);
      if (vld) begin
        exp_i = mem_word(pc_exp);
        chk("rand_pc_out", pc_out, pc_exp);
        chk("rand_instr", instr, exp_i);
        chk("rand_imm", 32'(imm), 32'(exp_i[31:7]));
        chk("rand_pcplus4", pc4, pc_exp + 32'd4);
        chkb("rand_no_req_when_valid", req, 1'b0);
      end
      if (!req) begin
        held = -1;
      end else if (held < 0 || addr != last_addr) begin
        held = 0;
        lat = $urandom_range(1, 3);
        last_addr = addr;
      end else begin
        held++;
      end
      ack = req && (held >= lat);
      rd = mem_word(addr);
      if (ack) held = -1;
      pcsrc = ($urandom_range(0, 9) == 0);
      tgt = 32'($urandom_range(0, 4095));
      rdy = 1'($urandom_range(0, 1));
      if (pcsrc) begin
        pc_exp = tgt & ~32'h3;
      end else if (vld && rdy) begin
        pc_exp = pc_exp + 32'd4;
        accepted++;
      end
      step();
    end
    ack = 1'b0; pcsrc = 1'b0; rdy = 1'b0;
    chkb("rand_no_fetch_err", err, 1'b0);
    chkb("rand_progress", accepted >= 50, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
